// File: rtl/inst_packer_pkg.sv
// Shared types for the RV32I instruction packer.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package inst_packer_pkg;

  // Immediate format selector; values 6 and 7 are unused encodings.
  typedef enum logic [2:0] {
    SEL_I     = 3'd0,
    SEL_S     = 3'd1,
    SEL_B     = 3'd2,
    SEL_U     = 3'd3,
    SEL_J     = 3'd4,
    SEL_SHAMT = 3'd5
  } inst_sel_e;

  // One FIFO entry: packed instruction plus its out-of-range flag.
  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } pack_ent_t;

  // True when v survives truncation to 'bits' bits and sign extension back,
  // i.e. v[31:bits-1] are all equal.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic signed [31:0] t;
    t = $signed(v << (32 - bits)) >>> (32 - bits);
    return (t == $signed(v));
  endfunction

endpackage

// File: rtl/inst_packer_if.sv
// Input item stream and output instruction stream of the packer.
// Latency: n/a (signal bundle).
// Backpressure: in_ready from the packer, out_ready from the consumer.
// Ports: in_valid/in_ready/in_sel/in_base/in_imm (producer side),
//        out_valid/out_ready/out_inst/out_err/out_count (consumer side).
interface inst_packer_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_sel;
  logic [31:0]      in_base;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic             out_err;
  logic [CNT_W-1:0] out_count;

  // Environment side: drives items and consumer ready.
  modport master (
    output in_valid, in_sel, in_base, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_err, out_count
  );

  // Packer side.
  modport slave (
    input  in_valid, in_sel, in_base, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_err, out_count
  );
endinterface

// File: rtl/sync_fifo.sv
// In-order circular FIFO holding DEPTH entries of payload type T.
// Latency: a push is visible at dout_o the cycle after the pushing edge.
// Backpressure: caller keeps pushes within capacity; pop on empty is ignored.
// Ports: clk, rst (async active-low), push_i/din_i, pop_i, dout_o (head), occ_o.
module sync_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  T                       din_i,
  input  logic                   pop_i,
  output T                       dout_o,
  output logic [$clog2(DEPTH):0] occ_o
);
  localparam int             AW     = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_V = (AW+1)'(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   occ_q, occ_d;
  logic          push_eff, pop_eff;

  assign pop_eff  = pop_i && (occ_q != '0);
  // A push into a full FIFO is allowed only when the head leaves on the same edge.
  assign push_eff = push_i && ((occ_q != FULL_V) || pop_eff);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    if (push_eff) wr_d = wr_q + 1'b1;
    if (pop_eff)  rd_d = rd_q + 1'b1;
    case ({push_eff, pop_eff})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end

  assign dout_o = mem_q[rd_q];
  assign occ_o  = occ_q;
endmodule

// File: rtl/inst_packer.sv
// Packs a typed immediate into an RV32I instruction word and flags unrepresentable immediates.
// Latency: 2 cycles accept-to-out_valid with the FIFO empty; one item per cycle sustained.
// Backpressure: in_ready = (fifo occupancy + encode stage) < DEPTH, independent of out_ready.
// Ports: clk, rst (async active-low), bus (inst_packer_if.slave: input stream, output stream, pop count).
module inst_packer
  import inst_packer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  inst_packer_if.slave bus
);
  localparam int            AW     = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_V = (AW+2)'(DEPTH);

  pack_ent_t        enc;
  pack_ent_t        s1_q, s1_d;
  logic             s1_vld_q, s1_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pack_ent_t        head;
  logic [AW:0]      occ;
  logic [AW+1:0]    used;
  logic             accept, pop;

  // Encode: start from the template and overwrite only the immediate fields.
  always_comb begin
    enc.inst = bus.in_base;
    enc.err  = 1'b0;
    case (bus.in_sel)
      SEL_I: begin
        enc.inst[31:20] = bus.in_imm[11:0];
        enc.err         = !fits_signed(bus.in_imm, 12);
      end
      SEL_S: begin
        enc.inst[31:25] = bus.in_imm[11:5];
        enc.inst[11:7]  = bus.in_imm[4:0];
        enc.err         = !fits_signed(bus.in_imm, 12);
      end
      SEL_B: begin
        enc.inst[31]    = bus.in_imm[12];
        enc.inst[30:25] = bus.in_imm[10:5];
        enc.inst[11:8]  = bus.in_imm[4:1];
        enc.inst[7]     = bus.in_imm[11];
        enc.err         = bus.in_imm[0] || !fits_signed(bus.in_imm, 13);
      end
      SEL_U: begin
        enc.inst[31:12] = bus.in_imm[31:12];
        enc.err         = (bus.in_imm[11:0] != '0);
      end
      SEL_J: begin
        enc.inst[31]    = bus.in_imm[20];
        enc.inst[30:21] = bus.in_imm[10:1];
        enc.inst[20]    = bus.in_imm[11];
        enc.inst[19:12] = bus.in_imm[19:12];
        enc.err         = bus.in_imm[0] || !fits_signed(bus.in_imm, 21);
      end
      SEL_SHAMT: begin
        enc.inst[24:20] = bus.in_imm[4:0];
        enc.err         = (bus.in_imm[31:5] != '0);
      end
      default: enc.err = 1'b1;
    endcase
  end

  // Counting the encode stage as occupied reserves its FIFO slot at accept time,
  // so the unconditional S1 push below can never overflow.
  assign used         = {1'b0, occ} + {{(AW+1){1'b0}}, s1_vld_q};
  assign bus.in_ready = rst && (used < DEPTH_V);
  assign accept       = bus.in_valid && bus.in_ready;
  assign pop          = bus.out_valid && bus.out_ready;

  always_comb begin
    s1_vld_d = accept;
    s1_d     = accept ? enc : s1_q;
    cnt_d    = cnt_q + CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld_q <= 1'b0;
      s1_q     <= '0;
      cnt_q    <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_q     <= s1_d;
      cnt_q    <= cnt_d;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .T     (pack_ent_t)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (s1_vld_q),
    .din_i  (s1_q),
    .pop_i  (pop),
    .dout_o (head),
    .occ_o  (occ)
  );

  // Head data is masked while empty so outputs read as zero out of reset.
  assign bus.out_valid = (occ != '0);
  assign bus.out_inst  = bus.out_valid ? head.inst : 32'h0;
  assign bus.out_err   = bus.out_valid ? head.err  : 1'b0;
  assign bus.out_count = cnt_q;
endmodule

// File: tb/tb_inst_packer.sv
module tb_inst_packer;
  import inst_packer_pkg::*;

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  exp_t sbq[$];
  int   pop_cyc[$];
  int   acc_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inst_packer_if #(.CNT_W(16)) bus ();

  inst_packer #(
    .DEPTH (4),
    .CNT_W (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Presents one item for one cycle; the expected result is queued only if it is taken.
  task automatic offer(input logic [2:0] sel, input logic [31:0] base, input logic [31:0] imm,
                       input logic [31:0] exp_inst, input logic exp_err, output bit acc);
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_base  = base;
    bus.in_imm   = imm;
    @(negedge clk);
    acc = bus.in_ready;
    if (acc) begin
      sbq.push_back('{exp_inst, exp_err});
      acc_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] sel, input logic [31:0] base, input logic [31:0] imm,
                      input logic [31:0] exp_inst, input logic exp_err);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      offer(sel, base, imm, exp_inst, exp_err, acc);
      n++;
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while ((sbq.size() != 0 || bus.out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(nm, sbq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sbq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every pop against the scoreboard and checks head stability under stall.
  logic        hold_armed = 1'b0;
  logic [31:0] held_inst;
  logic        held_err;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      hold_armed = 1'b0;
    end else begin
      if (hold_armed && bus.out_valid) begin
        chk("hold_inst", bus.out_inst, held_inst);
        chk("hold_err", bus.out_err, held_err);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pop: got inst %h, required no output", bus.out_inst);
        end else begin
          mon_e = sbq.pop_front();
          chk("pop_inst", bus.out_inst, mon_e.inst);
          chk("pop_err", bus.out_err, mon_e.err);
        end
        pop_cyc.push_back(cyc);
      end
      hold_armed = bus.out_valid && !bus.out_ready;
      held_inst  = bus.out_inst;
      held_err   = bus.out_err;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int acc_n;
    bit stale;

    bus.in_valid  = 1'b0;
    bus.in_sel    = 3'd0;
    bus.in_base   = 32'h0;
    bus.in_imm    = 32'h0;
    bus.out_ready = 1'b0;
    rst           = 1'b0;

    // Reset state
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_inst", bus.out_inst, 32'h0);
    chk("rst_out_err", bus.out_err, 0);
    chk("rst_out_count", bus.out_count, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // I-type with 2-cycle latency
    bus.out_ready = 1'b1;
    send(SEL_I, 32'h00000093, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
    @(negedge clk);
    chk("lat_edge_n", bus.out_valid, 0);
    @(negedge clk);
    chk("lat_edge_n1", bus.out_valid, 1);
    @(posedge clk);
    #1;
    wait_drain("drain_i");

    // B, J, U, S, SHAMT and unused selector
    send(SEL_B, 32'h00000063, 32'h00000010, 32'h00000863, 1'b0);
    send(SEL_B, 32'h00000063, 32'h00000011, 32'h00000863, 1'b1);
    send(SEL_J, 32'h0000006F, 32'h00000800, 32'h0010006F, 1'b0);
    send(SEL_U, 32'h00000037, 32'h12345678, 32'h12345037, 1'b1);
    send(SEL_S, 32'h00002023, 32'hFFFFF800, 32'h80002023, 1'b0);
    send(SEL_S, 32'h00002023, 32'h00000800, 32'h80002023, 1'b1);
    send(SEL_SHAMT, 32'h00001013, 32'h0000001F, 32'h01F01013, 1'b0);
    send(SEL_SHAMT, 32'h00001013, 32'h00000020, 32'h00001013, 1'b1);
    send(3'd6, 32'h12345678, 32'h00000000, 32'h12345678, 1'b1);
    wait_drain("drain_mix");

    // Backpressure: 6 offered, DEPTH accepted
    bus.out_ready = 1'b0;
    do_reset();
    acc_n = 0;
    for (int i = 0; i < 6; i++) begin
      offer(SEL_I, 32'h00000013, 32'(i + 1), (32'(i + 1) << 20) | 32'h13, 1'b0, acc);
      acc_n += int'(acc);
    end
    chk("bp_accepted", acc_n, 4);
    @(negedge clk);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_count0", bus.out_count, 0);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_drain("drain_bp");
    chk("bp_count4", bus.out_count, 4);

    // Streaming: 10 back-to-back
    do_reset();
    pop_cyc.delete();
    acc_cyc.delete();
    acc_n = 0;
    for (int i = 0; i < 10; i++) begin
      offer(SEL_U, 32'h00000037, 32'(i) << 12, (32'(i) << 12) | 32'h37, 1'b0, acc);
      acc_n += int'(acc);
    end
    chk("st_accepted", acc_n, 10);
    wait_drain("drain_st");
    chk("st_count", bus.out_count, 10);
    chk("st_pops", pop_cyc.size(), 10);
    if (pop_cyc.size() == 10 && acc_cyc.size() == 10) begin
      chk("st_span", pop_cyc[9] - pop_cyc[0], 9);
      chk("st_fill", pop_cyc[0] - acc_cyc[0], 2);
    end else begin
      tests++;
      fails++;
      $display("FAIL st_stamps: got %0d pops / %0d accepts, required 10 each", pop_cyc.size(), acc_cyc.size());
    end

    // Reset mid-stream with 3 items pending
    bus.out_ready = 1'b0;
    send(SEL_I, 32'h00000013, 32'h00000001, 32'h00100013, 1'b0);
    send(SEL_I, 32'h00000013, 32'h00000002, 32'h00200013, 1'b0);
    send(SEL_I, 32'h00000013, 32'h00000003, 32'h00300013, 1'b0);
    #2 rst = 1'b0;
    sbq.delete();
    #1;
    chk("mr_out_valid", bus.out_valid, 0);
    chk("mr_out_count", bus.out_count, 0);
    chk("mr_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mr_rel_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    stale = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) stale = 1'b1;
    end
    chk("mr_no_stale", stale, 0);
    @(posedge clk);
    #1;
    send(SEL_I, 32'h00000093, 32'h000007FF, 32'h7FF00093, 1'b0);
    wait_drain("drain_mr");
    chk("mr_count1", bus.out_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/inst_packer.md
Name: inst_packer

Overview:
- Instruction assembler: packs a typed immediate into a 32-bit RV32I instruction word, the inverse of the immediate-generation path.
- Feeds the instruction-memory preload / test-injection path.
- Inputs arrive on a valid/ready stream. A one-stage encode register and an output FIFO decouple them from the consumer.
- Flags immediates that the selected format cannot represent, and counts delivered instructions.

Parameters:
- DEPTH, 4, output FIFO entries (power of two, at least 2)
- CNT_W, 16, width of the delivered-instruction counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  input item valid
- in_ready  out  1  block can accept an item
- in_sel  in  3  format selector (package constants)
- in_base  in  32  instruction template (opcode/rd/rs/funct); immediate-field bits are overwritten
- in_imm  in  32  immediate value, two's complement
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_inst  out  32  packed instruction at FIFO head
- out_err  out  1  head immediate not exactly representable
- out_count  out  CNT_W  instructions popped since reset

Behaviour:
- Handshakes:
  - Accept when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = (fifo_occ + s1_valid) < DEPTH. It depends on state only, never on out_ready.
  - in_ready is 0 while rst is low.
- Pipeline:
  - An accepted item is encoded and captured in stage S1 at edge N.
  - S1 is pushed into the FIFO at edge N+1, so out_valid rises after N+1 (2-cycle latency with the FIFO empty).
  - Full throughput: one accept and one pop per cycle in steady state.
- Bit placement; all bits not listed come from in_base:
  - SEL_I: inst[31:20]=imm[11:0].
  - SEL_S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0].
  - SEL_B: inst[31]=imm[12], inst[30:25]=imm[10:5], inst[11:8]=imm[4:1], inst[7]=imm[11].
  - SEL_U: inst[31:12]=imm[31:12].
  - SEL_J: inst[31]=imm[20], inst[30:21]=imm[10:1], inst[20]=imm[11], inst[19:12]=imm[19:12].
  - SEL_SHAMT: inst[24:20]=imm[4:0]; inst[31:25] come from in_base.
  - Selector values 6 and 7: inst = in_base, err = 1.
- err is 1 when:
  - SEL_I / SEL_S: imm[31:11] is not all-equal.
  - SEL_B: imm[0]=1 or imm[31:12] is not all-equal.
  - SEL_U: imm[11:0] is not 0.
  - SEL_J: imm[0]=1 or imm[31:20] is not all-equal.
  - SEL_SHAMT: imm[31:5] is not 0.
  - An erroneous item is still packed (truncated) and delivered, with out_err=1 alongside it.
- FIFO: in order, circular pointers wrap at DEPTH. When full and empty are simultaneous (push and pop in the same edge), occupancy is unchanged.
- Holding: out_inst and out_err hold stable while out_valid && !out_ready.
- out_count increments by 1 per pop and wraps at 2^CNT_W.
- Reset (async, any time), with no partial items surviving:
  - S1 and the FIFO are cleared; out_valid=0, out_inst=0, out_err=0, out_count=0.
  - in_ready=1 from the first edge after rst is released.

Decomposition:
- Shared package holds:
  - the inst_sel_e typedef: SEL_I=0, SEL_S=1, SEL_B=2, SEL_U=3, SEL_J=4, SEL_SHAMT=5;
  - the packed struct {logic [31:0] inst; logic err;} used for FIFO entries.
- Sub-module sync_fifo (parameters DEPTH, payload type) holds the storage and occupancy logic.
- Encode logic and the range check live in inst_packer.

Test Plan:
- I-type: base 0x00000093, imm 0xFFFFFFFF, SEL_I, out_ready=1 -> out_inst 0xFFF00093, err 0, out_valid two cycles after accept.
- B-type: base 0x00000063, imm 0x00000010 -> 0x00000863, err 0. Then imm 0x00000011 -> err 1.
- J/U-type:
  - base 0x0000006F, imm 0x00000800, SEL_J -> 0x0010006F, err 0.
  - base 0x00000037, imm 0x12345678, SEL_U -> 0x12345037, err 1.
- Backpressure: out_ready=0, offer 6 items -> exactly DEPTH=4 accepted and in_ready low. Raise out_ready -> 4 pops in order, out_count=4.
- Streaming: 10 back-to-back items with out_ready=1 -> one pop per cycle after 2-cycle fill, order preserved, out_count=10.
- Reset mid-stream with 3 items pending -> out_valid 0 and out_count 0 immediately. in_ready=1 after release, and no stale items appear.
